// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline sequencer and the datapath around it:
// FSM state encoding, register-address constants, NOP encoding for bubbles
// and the packed bundle of pipeline-register controls.
package pipe_ctrl_pkg;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned REG_AW = 5;
  localparam int unsigned CNT_W  = $clog2(16);

  localparam logic [REG_AW-1:0] REG_ZERO = 5'd0;

  // Instruction the datapath loads into RR/EX when bubble_EX is set (addi x0,x0,0)
  localparam logic [XLEN-1:0] NOP_INSN = 32'h0000_0013;
  localparam logic [REG_AW-1:0] NOP_RD = REG_ZERO;

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_LDSTALL = 2'd1,
    ST_MCWAIT  = 2'd2
  } state_t;

  typedef struct packed {
    logic en_if;
    logic en_id;
    logic en_rr;
    logic en_ex;
    logic flush_id;
    logic flush_rr;
    logic bubble_ex;
  } pipe_ctl_t;

  localparam pipe_ctl_t CTL_RUN    = '{en_if: 1'b1, en_id: 1'b1, en_rr: 1'b1, en_ex: 1'b1,
                                       flush_id: 1'b0, flush_rr: 1'b0, bubble_ex: 1'b0};
  localparam pipe_ctl_t CTL_FREEZE = '{en_if: 1'b0, en_id: 1'b0, en_rr: 1'b0, en_ex: 1'b0,
                                       flush_id: 1'b0, flush_rr: 1'b0, bubble_ex: 1'b0};
  localparam pipe_ctl_t CTL_LDBUB  = '{en_if: 1'b0, en_id: 1'b0, en_rr: 1'b0, en_ex: 1'b1,
                                       flush_id: 1'b0, flush_rr: 1'b0, bubble_ex: 1'b1};
  localparam pipe_ctl_t CTL_BRANCH = '{en_if: 1'b1, en_id: 1'b1, en_rr: 1'b1, en_ex: 1'b1,
                                       flush_id: 1'b1, flush_rr: 1'b1, bubble_ex: 1'b1};
  localparam pipe_ctl_t CTL_RESET  = '{en_if: 1'b0, en_id: 1'b0, en_rr: 1'b0, en_ex: 1'b0,
                                       flush_id: 1'b1, flush_rr: 1'b1, bubble_ex: 1'b1};

endpackage

// File: rtl/pipe_hazard_ctrl_ld_use_cmp.sv
// Load-use hazard detector: flags an RR-stage operand read of the register
// that the load currently in EX will write. Register 0 never hazards.
// Ports: r1_addr/r2_addr (RR sources), use_mask (bit0 R1, bit1 R2),
//        r3_addr (EX destination), ld (EX is a load), hz (hazard, comb).
module ld_use_cmp
  import pipe_ctrl_pkg::*;
(
  input  logic [REG_AW-1:0] r1_addr,
  input  logic [REG_AW-1:0] r2_addr,
  input  logic [1:0]        use_mask,
  input  logic [REG_AW-1:0] r3_addr,
  input  logic              ld,
  output logic              hz
);

  logic r1_hit;
  logic r2_hit;

  assign r1_hit = use_mask[0] & (r1_addr == r3_addr);
  assign r2_hit = use_mask[1] & (r2_addr == r3_addr);
  assign hz     = ld & (r3_addr != REG_ZERO) & (r1_hit | r2_hit);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline sequencer: drives enables/flushes of IF/ID, ID/RR and RR/EX from
// load-use hazards, multi-cycle EX ops, taken branches and memory stalls.
// Ports: clk, reset (sync, active-high); RR/EX register addresses and
//        hazard qualifiers in; en_IF/ID/RR/EX, flush_ID/RR, bubble_EX
//        (combinational, zero latency), state, stall_cycles out.
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned MUL_LAT    = 4,
  parameter int unsigned LD_BUBBLES = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [REG_AW-1:0] R1_addr_RR,
  input  logic [REG_AW-1:0] R2_addr_RR,
  input  logic [1:0]        use_RR,
  input  logic [REG_AW-1:0] R3_addr_EX,
  input  logic              ld_EX,
  input  logic              mc_start_EX,
  input  logic              br_taken_EX,
  input  logic              stall_req,
  output logic              en_IF,
  output logic              en_ID,
  output logic              en_RR,
  output logic              en_EX,
  output logic              flush_ID,
  output logic              flush_RR,
  output logic              bubble_EX,
  output logic [1:0]        state,
  output logic [XLEN-1:0]   stall_cycles
);

  // Reload values; guarded so small parameter values never wrap
  localparam int unsigned MC_LOAD_I = (MUL_LAT > 2) ? (MUL_LAT - 2) : 0;
  localparam int unsigned LD_LOAD_I = (LD_BUBBLES > 2) ? (LD_BUBBLES - 2) : 0;
  localparam logic [CNT_W-1:0] MC_LOAD = CNT_W'(MC_LOAD_I);
  localparam logic [CNT_W-1:0] LD_LOAD = CNT_W'(LD_LOAD_I);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [XLEN-1:0]  stall_q;
  pipe_ctl_t        ctl;
  logic             hz;

  ld_use_cmp u_ld_use_cmp (
    .r1_addr  (R1_addr_RR),
    .r2_addr  (R2_addr_RR),
    .use_mask (use_RR),
    .r3_addr  (R3_addr_EX),
    .ld       (ld_EX),
    .hz       (hz)
  );

  // State, wait counter and stall perf counter
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_RUN;
      cnt_q   <= '0;
      stall_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (!ctl.en_rr && (stall_q != '1)) begin
        stall_q <= stall_q + 32'd1;
      end
    end
  end

  // Next state and pipeline controls; stall_req freezes state and counter
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ctl     = CTL_RUN;
    if (reset) begin
      ctl = CTL_RESET;
    end else if (stall_req) begin
      ctl = CTL_FREEZE;
    end else begin
      unique case (state_q)
        ST_RUN: begin
          if (br_taken_EX) begin
            // Wrong-path instructions in IF/ID and ID/RR are squashed
            ctl = CTL_BRANCH;
          end else if (mc_start_EX) begin
            if (MUL_LAT > 1) begin
              ctl = CTL_FREEZE;
              if (MUL_LAT > 2) begin
                cnt_d   = MC_LOAD;
                state_d = ST_MCWAIT;
              end
            end
          end else if (hz) begin
            ctl = CTL_LDBUB;
            if (LD_BUBBLES > 1) begin
              cnt_d   = LD_LOAD;
              state_d = ST_LDSTALL;
            end
          end
        end
        ST_LDSTALL: begin
          // cnt counts the remaining extra bubbles after this one
          ctl = CTL_LDBUB;
          if (cnt_q == '0) begin
            state_d = ST_RUN;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
        ST_MCWAIT: begin
          // cnt counts the remaining MCWAIT cycles including this one
          ctl = CTL_FREEZE;
          if (cnt_q != '0) begin
            cnt_d = cnt_q - CNT_W'(1);
          end
          if (cnt_q <= CNT_W'(1)) begin
            state_d = ST_RUN;
          end
        end
        default: begin
          state_d = ST_RUN;
          cnt_d   = '0;
        end
      endcase
    end
  end

  assign en_IF        = ctl.en_if;
  assign en_ID        = ctl.en_id;
  assign en_RR        = ctl.en_rr;
  assign en_EX        = ctl.en_ex;
  assign flush_ID     = ctl.flush_id;
  assign flush_RR     = ctl.flush_rr;
  assign bubble_EX    = ctl.bubble_ex;
  assign state        = state_q;
  assign stall_cycles = stall_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: three parameterisations share
// one stimulus bus; expected outputs go into a scoreboard queue when driven
// and are compared on the falling edge of the same cycle.
module tb_pipe_hazard_ctrl;

  typedef struct packed {
    logic       rst;
    logic [4:0] r1;
    logic [4:0] r2;
    logic [1:0] um;
    logic [4:0] r3;
    logic       ld;
    logic       mc;
    logic       br;
    logic       stl;
  } vin_t;

  typedef struct packed {
    logic [3:0]  en;
    logic [1:0]  fl;
    logic        bub;
    logic [1:0]  st;
    logic [31:0] sc;
  } vout_t;

  typedef struct {
    vin_t  i;
    vout_t o;
    string name;
  } row_t;

  typedef struct {
    string       name;
    int unsigned dut;
    vout_t       exp;
  } sb_t;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] r1_addr, r2_addr, r3_addr;
  logic [1:0] use_rr;
  logic       ld_ex, mc_start, br_taken, stall_req;

  logic       a_if, a_id, a_rr, a_ex, a_fid, a_frr, a_bub;
  logic       b_if, b_id, b_rr, b_ex, b_fid, b_frr, b_bub;
  logic       c_if, c_id, c_rr, c_ex, c_fid, c_frr, c_bub;
  logic [1:0] a_st, b_st, c_st;
  logic [31:0] a_sc, b_sc, c_sc;
  vout_t      oa, ob, oc;

  sb_t  sb_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  row_t tbl[19];

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.MUL_LAT(4), .LD_BUBBLES(1)) dut_a (
    .clk(clk), .reset(reset), .R1_addr_RR(r1_addr), .R2_addr_RR(r2_addr),
    .use_RR(use_rr), .R3_addr_EX(r3_addr), .ld_EX(ld_ex), .mc_start_EX(mc_start),
    .br_taken_EX(br_taken), .stall_req(stall_req),
    .en_IF(a_if), .en_ID(a_id), .en_RR(a_rr), .en_EX(a_ex), .flush_ID(a_fid),
    .flush_RR(a_frr), .bubble_EX(a_bub), .state(a_st), .stall_cycles(a_sc)
  );

  pipe_hazard_ctrl #(.MUL_LAT(8), .LD_BUBBLES(3)) dut_b (
    .clk(clk), .reset(reset), .R1_addr_RR(r1_addr), .R2_addr_RR(r2_addr),
    .use_RR(use_rr), .R3_addr_EX(r3_addr), .ld_EX(ld_ex), .mc_start_EX(mc_start),
    .br_taken_EX(br_taken), .stall_req(stall_req),
    .en_IF(b_if), .en_ID(b_id), .en_RR(b_rr), .en_EX(b_ex), .flush_ID(b_fid),
    .flush_RR(b_frr), .bubble_EX(b_bub), .state(b_st), .stall_cycles(b_sc)
  );

  pipe_hazard_ctrl #(.MUL_LAT(1), .LD_BUBBLES(2)) dut_c (
    .clk(clk), .reset(reset), .R1_addr_RR(r1_addr), .R2_addr_RR(r2_addr),
    .use_RR(use_rr), .R3_addr_EX(r3_addr), .ld_EX(ld_ex), .mc_start_EX(mc_start),
    .br_taken_EX(br_taken), .stall_req(stall_req),
    .en_IF(c_if), .en_ID(c_id), .en_RR(c_rr), .en_EX(c_ex), .flush_ID(c_fid),
    .flush_RR(c_frr), .bubble_EX(c_bub), .state(c_st), .stall_cycles(c_sc)
  );

  assign oa = {a_if, a_id, a_rr, a_ex, a_fid, a_frr, a_bub, a_st, a_sc};
  assign ob = {b_if, b_id, b_rr, b_ex, b_fid, b_frr, b_bub, b_st, b_sc};
  assign oc = {c_if, c_id, c_rr, c_ex, c_fid, c_frr, c_bub, c_st, c_sc};

  function automatic vin_t mi(input logic rst, input logic [4:0] r1, input logic [4:0] r2,
                              input logic [1:0] um, input logic [4:0] r3, input logic ld,
                              input logic mc, input logic br, input logic stl);
    vin_t v;
    v = {rst, r1, r2, um, r3, ld, mc, br, stl};
    return v;
  endfunction

  function automatic vout_t mo(input logic [3:0] en, input logic [1:0] fl, input logic bub,
                               input logic [1:0] st, input int unsigned sc);
    vout_t o;
    o = {en, fl, bub, st, 32'(sc)};
    return o;
  endfunction

  task automatic drive(input vin_t v);
    reset     = v.rst;
    r1_addr   = v.r1;
    r2_addr   = v.r2;
    use_rr    = v.um;
    r3_addr   = v.r3;
    ld_ex     = v.ld;
    mc_start  = v.mc;
    br_taken  = v.br;
    stall_req = v.stl;
  endtask

  // One cycle: drive after the rising edge and queue the expected outputs
  task automatic apply(input vin_t v, input vout_t e, input string nm, input int unsigned d);
    sb_t s;
    @(posedge clk);
    #1;
    drive(v);
    s.name = nm;
    s.dut  = d;
    s.exp  = e;
    sb_q.push_back(s);
  endtask

  task automatic apply_nochk(input vin_t v);
    @(posedge clk);
    #1;
    drive(v);
  endtask

  // Scoreboard checker on the falling edge
  always @(negedge clk) begin
    sb_t   s;
    vout_t got;
    if (sb_q.size() != 0) begin
      s = sb_q.pop_front();
      case (s.dut)
        0:       got = oa;
        1:       got = ob;
        default: got = oc;
      endcase
      n_tests++;
      if (got !== s.exp) begin
        n_fail++;
        $display("FAIL %s: got en=%b fl=%b bub=%b st=%0d sc=%0d, expected en=%b fl=%b bub=%b st=%0d sc=%0d",
                 s.name, got.en, got.fl, got.bub, got.st, got.sc,
                 s.exp.en, s.exp.fl, s.exp.bub, s.exp.st, s.exp.sc);
      end
    end
  end

  // Input protocol: a taken branch and a multi-cycle start never coincide
  always @(posedge clk) begin
    if (reset === 1'b0) begin
      assert (!(mc_start && br_taken))
        else $error("protocol: mc_start_EX and br_taken_EX together");
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vin_t idle;
    idle = mi(1'b0, 5'd0, 5'd0, 2'b00, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);

    // dut_a: MUL_LAT=4, LD_BUBBLES=1
    tbl[0]  = '{mi(1, 0, 0, 2'b00, 0, 0, 0, 0, 0), mo(4'b0000, 2'b11, 1, 0, 0), "reset"};
    tbl[1]  = '{idle,                              mo(4'b1111, 2'b00, 0, 0, 0), "idle"};
    tbl[2]  = '{mi(0, 5, 0, 2'b01, 5, 1, 0, 0, 0), mo(4'b0001, 2'b00, 1, 0, 0), "ld_use_r1"};
    tbl[3]  = '{idle,                              mo(4'b1111, 2'b00, 0, 0, 1), "after_ld_use"};
    tbl[4]  = '{mi(0, 0, 0, 2'b01, 0, 1, 0, 0, 0), mo(4'b1111, 2'b00, 0, 0, 1), "r0_no_hz"};
    tbl[5]  = '{mi(0, 0, 7, 2'b01, 7, 1, 0, 0, 0), mo(4'b1111, 2'b00, 0, 0, 1), "unused_r2"};
    tbl[6]  = '{mi(0, 0, 7, 2'b10, 7, 1, 0, 0, 0), mo(4'b0001, 2'b00, 1, 0, 1), "ld_use_r2"};
    tbl[7]  = '{mi(0, 7, 7, 2'b11, 7, 0, 0, 0, 0), mo(4'b1111, 2'b00, 0, 0, 2), "no_load"};
    tbl[8]  = '{mi(0, 9, 0, 2'b01, 9, 1, 0, 1, 0), mo(4'b1111, 2'b11, 1, 0, 2), "branch_with_hz"};
    tbl[9]  = '{idle,                              mo(4'b1111, 2'b00, 0, 0, 2), "after_branch"};
    tbl[10] = '{mi(0, 0, 0, 2'b00, 0, 0, 0, 0, 1), mo(4'b0000, 2'b00, 0, 0, 2), "stall_run"};
    tbl[11] = '{idle,                              mo(4'b1111, 2'b00, 0, 0, 3), "after_stall"};
    tbl[12] = '{mi(0, 0, 0, 2'b00, 0, 0, 0, 1, 1), mo(4'b0000, 2'b00, 0, 0, 3), "stall_over_branch"};
    tbl[13] = '{mi(0, 0, 0, 2'b00, 0, 0, 1, 0, 0), mo(4'b0000, 2'b00, 0, 0, 4), "mc_start"};
    tbl[14] = '{idle,                              mo(4'b0000, 2'b00, 0, 2, 5), "mcwait_1"};
    tbl[15] = '{mi(0, 5, 0, 2'b01, 5, 1, 0, 1, 0), mo(4'b0000, 2'b00, 0, 2, 6), "mcwait_2_ignores_br_hz"};
    tbl[16] = '{idle,                              mo(4'b1111, 2'b00, 0, 0, 7), "mc_done"};
    tbl[17] = '{mi(0, 0, 0, 2'b00, 0, 0, 1, 0, 1), mo(4'b0000, 2'b00, 0, 0, 7), "stall_over_mc"};
    tbl[18] = '{idle,                              mo(4'b1111, 2'b00, 0, 0, 8), "after_stall_mc"};

    drive(mi(1, 0, 0, 2'b00, 0, 0, 0, 0, 0));
    for (int i = 0; i < 19; i++) begin
      apply(tbl[i].i, tbl[i].o, tbl[i].name, 0);
    end

    // dut_b: LDSTALL frozen by stall_req, then reset aborting MCWAIT
    apply_nochk(mi(1, 0, 0, 2'b00, 0, 0, 0, 0, 0));
    apply(mi(0, 5, 0, 2'b01, 5, 1, 0, 0, 0), mo(4'b0001, 2'b00, 1, 0, 0), "b_hz", 1);
    apply(idle,                              mo(4'b0001, 2'b00, 1, 1, 1), "b_ldstall", 1);
    apply(mi(0, 0, 0, 2'b00, 0, 0, 0, 0, 1), mo(4'b0000, 2'b00, 0, 1, 2), "b_freeze_1", 1);
    apply(mi(0, 0, 0, 2'b00, 0, 0, 0, 0, 1), mo(4'b0000, 2'b00, 0, 1, 3), "b_freeze_2", 1);
    apply(mi(0, 0, 0, 2'b00, 0, 0, 0, 1, 0), mo(4'b0001, 2'b00, 1, 1, 4), "b_ldstall_ignores_br", 1);
    apply(idle,                              mo(4'b1111, 2'b00, 0, 0, 5), "b_run_total5", 1);
    apply(mi(0, 0, 0, 2'b00, 0, 0, 1, 0, 0), mo(4'b0000, 2'b00, 0, 0, 5), "b_mc_start", 1);
    apply(mi(1, 0, 0, 2'b00, 0, 0, 0, 0, 0), mo(4'b0000, 2'b11, 1, 2, 6), "b_reset_in_mcwait", 1);
    apply(idle,                              mo(4'b1111, 2'b00, 0, 0, 0), "b_after_reset", 1);

    // dut_c: MUL_LAT=1 never stalls, LD_BUBBLES=2 gives one LDSTALL cycle
    apply_nochk(mi(1, 0, 0, 2'b00, 0, 0, 0, 0, 0));
    apply(mi(0, 0, 0, 2'b00, 0, 0, 1, 0, 0), mo(4'b1111, 2'b00, 0, 0, 0), "c_mc_lat1", 2);
    apply(mi(0, 0, 3, 2'b10, 3, 1, 0, 0, 0), mo(4'b0001, 2'b00, 1, 0, 0), "c_hz", 2);
    apply(idle,                              mo(4'b0001, 2'b00, 1, 1, 1), "c_ldstall", 2);
    apply(idle,                              mo(4'b1111, 2'b00, 0, 0, 2), "c_run", 2);

    @(negedge clk);
    #1;
    if (sb_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
